// File: rtl/motion_phase_tracker_if.sv
// Purpose : bundles the calculator-side inputs and step-generator-side outputs of motion_phase_tracker.
// Ports   : start/timings_valid/hold and five 4-entry timing tables in; elapsed, axis_active,
//           axis_seg, busy, finish, error out. slave = tracker side, master = driver side.
interface motion_phase_tracker_if #(
    parameter int CNT_W = 64
);
    // Move control from the sequencer / timing calculator
    logic             start;
    logic             timings_valid;
    logic             hold;

    // Cumulative segment boundaries t0..t3 per axis, in clk cycles
    logic [CNT_W-1:0] timing_x  [0:3];
    logic [CNT_W-1:0] timing_y  [0:3];
    logic [CNT_W-1:0] timing_z  [0:3];
    logic [CNT_W-1:0] timing_e0 [0:3];
    logic [CNT_W-1:0] timing_e1 [0:3];

    // Status towards the step generators
    logic [CNT_W-1:0] elapsed;
    logic [4:0]       axis_active;
    logic [1:0]       axis_seg  [0:4];
    logic             busy;
    logic             finish;
    logic             error;

    modport slave (
        input  start, timings_valid, hold,
        input  timing_x, timing_y, timing_z, timing_e0, timing_e1,
        output elapsed, axis_active, axis_seg, busy, finish, error
    );

    modport master (
        output start, timings_valid, hold,
        output timing_x, timing_y, timing_z, timing_e0, timing_e1,
        input  elapsed, axis_active, axis_seg, busy, finish, error
    );
endinterface

// File: rtl/motion_phase_tracker.sv
// Purpose : latches the five per-axis timing tables, checks them for monotonicity, then runs one
//           shared elapsed counter and reports each axis's active flag and current segment.
// Ports   : clk, reset (sync, active-high), bus (motion_phase_tracker_if.slave).
//           axis_active/axis_seg are combinational from registered state; everything else registered.
module motion_phase_tracker #(
    parameter int CNT_W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    motion_phase_tracker_if.slave  bus
);

    localparam int N_AXIS = 5;
    localparam int N_SEG  = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_elapsed;
    logic [CNT_W-1:0] r_tim [0:N_AXIS-1][0:N_SEG-1];

    logic [CNT_W-1:0] w_tin [0:N_AXIS-1][0:N_SEG-1];
    logic             w_latch;
    logic             w_mono_ok;
    logic [4:0]       w_active;
    logic [1:0]       w_seg [0:N_AXIS-1];
    logic             w_any_active;
    logic             w_elapsed_sat;
    logic             w_busy;
    logic             w_finish;
    logic             w_error;

    // ------------------------------------------------------------------
    // Gather the per-axis input tables into one array (axis order X,Y,Z,E0,E1)
    // ------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < N_SEG; j++) begin
            w_tin[0][j] = bus.timing_x[j];
            w_tin[1][j] = bus.timing_y[j];
            w_tin[2][j] = bus.timing_z[j];
            w_tin[3][j] = bus.timing_e0[j];
            w_tin[4][j] = bus.timing_e1[j];
        end
    end

    // Tables are captured only on the IDLE->CHECK transition; later input
    // changes cannot disturb a move in progress.
    assign w_latch = (r_state == S_IDLE) && bus.start && bus.timings_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < N_AXIS; a++) begin
                for (int j = 0; j < N_SEG; j++) begin
                    r_tim[a][j] <= '0;
                end
            end
        end else if (w_latch) begin
            for (int a = 0; a < N_AXIS; a++) begin
                for (int j = 0; j < N_SEG; j++) begin
                    r_tim[a][j] <= w_tin[a][j];
                end
            end
        end
    end

    // Monotonicity of the latched copies; only consulted in CHECK.
    always_comb begin
        w_mono_ok = 1'b1;
        for (int a = 0; a < N_AXIS; a++) begin
            if ((r_tim[a][0] > r_tim[a][1]) ||
                (r_tim[a][1] > r_tim[a][2]) ||
                (r_tim[a][2] > r_tim[a][3])) begin
                w_mono_ok = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-axis phase decode. Only meaningful in RUN; zero elsewhere so the
    // step generators see a quiet bus in IDLE/CHECK/DONE/ERR.
    // ------------------------------------------------------------------
    always_comb begin
        w_active = '0;
        for (int a = 0; a < N_AXIS; a++) begin
            w_seg[a] = 2'd0;
            if ((r_state == S_RUN) && (r_elapsed < r_tim[a][3])) begin
                w_active[a] = 1'b1;
                if (r_elapsed < r_tim[a][0]) begin
                    w_seg[a] = 2'd0;
                end else if (r_elapsed < r_tim[a][1]) begin
                    w_seg[a] = 2'd1;
                end else if (r_elapsed < r_tim[a][2]) begin
                    w_seg[a] = 2'd2;
                end else begin
                    w_seg[a] = 2'd3;
                end
            end
        end
    end

    assign w_any_active  = |w_active;
    assign w_elapsed_sat = &r_elapsed;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Dropping start aborts from any state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.start) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.timings_valid) begin
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    w_state_nxt = w_mono_ok ? S_RUN : S_ERR;
                end
                S_RUN: begin
                    // Completion is judged at the current elapsed value, so the
                    // cycle where the last axis expires is still a RUN cycle.
                    if (!w_any_active) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                S_ERR:   w_state_nxt = S_ERR;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        w_busy   = 1'b0;
        w_finish = 1'b0;
        w_error  = 1'b0;
        case (r_state)
            S_CHECK: w_busy   = 1'b1;
            S_RUN:   w_busy   = 1'b1;
            S_DONE:  w_finish = 1'b1;
            S_ERR:   w_error  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared elapsed counter. Held at 0 until RUN, advances only while some
    // axis is still active and hold is low, freezes in DONE, and saturates
    // rather than wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_elapsed <= '0;
        end else if (!bus.start) begin
            r_elapsed <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_CHECK: r_elapsed <= '0;
                S_RUN: begin
                    if (w_any_active && !bus.hold && !w_elapsed_sat) begin
                        r_elapsed <= r_elapsed + CNT_W'(1);
                    end
                end
                default: r_elapsed <= r_elapsed;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drive the interface
    // ------------------------------------------------------------------
    assign bus.elapsed     = r_elapsed;
    assign bus.axis_active = w_active;
    assign bus.busy        = w_busy;
    assign bus.finish      = w_finish;
    assign bus.error       = w_error;

    always_comb begin
        for (int a = 0; a < N_AXIS; a++) begin
            bus.axis_seg[a] = w_seg[a];
        end
    end

endmodule

// File: tb/tb_motion_phase_tracker.sv
// Purpose : self-checking bench for motion_phase_tracker; directed cases plus randomized moves
//           checked every cycle against a table-driven reference model.
// Ports   : none (top-level bench); drives the DUT through a motion_phase_tracker_if instance.
module tb_motion_phase_tracker;

    localparam int W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    motion_phase_tracker_if #(.CNT_W(W)) bus ();

    motion_phase_tracker #(.CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    string tname = "";

    // Timing tables of the move under test, axis order X,Y,Z,E0,E1.
    logic [W-1:0] cur_t [0:4][0:3];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s observed=%0d expected=%0d", tname, tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (straight from the move rules) ----------------
    function automatic logic [1:0] ref_seg(input int a, input int e);
        if (e >= cur_t[a][3]) return 2'd0;
        if (e < cur_t[a][0]) return 2'd0;
        if (e < cur_t[a][1]) return 2'd1;
        if (e < cur_t[a][2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [4:0] ref_active(input int e);
        logic [4:0] v;
        for (int a = 0; a < 5; a++) v[a] = (e < cur_t[a][3]);
        return v;
    endfunction

    function automatic logic [9:0] ref_segs(input int e);
        logic [9:0] v;
        for (int a = 0; a < 5; a++) v[2*a +: 2] = ref_seg(a, e);
        return v;
    endfunction

    function automatic bit ref_mono();
        for (int a = 0; a < 5; a++)
            if (cur_t[a][0] > cur_t[a][1] || cur_t[a][1] > cur_t[a][2] || cur_t[a][2] > cur_t[a][3])
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_max_t3();
        int m = 0;
        for (int a = 0; a < 5; a++) if (int'(cur_t[a][3]) > m) m = int'(cur_t[a][3]);
        return m;
    endfunction

    function automatic logic [9:0] obs_segs();
        return {bus.axis_seg[4], bus.axis_seg[3], bus.axis_seg[2], bus.axis_seg[1], bus.axis_seg[0]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_tables();
        for (int j = 0; j < 4; j++) begin
            bus.timing_x[j]  = cur_t[0][j];
            bus.timing_y[j]  = cur_t[1][j];
            bus.timing_z[j]  = cur_t[2][j];
            bus.timing_e0[j] = cur_t[3][j];
            bus.timing_e1[j] = cur_t[4][j];
        end
    endtask

    task automatic scramble_tables();
        for (int j = 0; j < 4; j++) begin
            bus.timing_x[j]  = W'($urandom_range(0, 40));
            bus.timing_y[j]  = W'($urandom_range(0, 40));
            bus.timing_z[j]  = W'($urandom_range(0, 40));
            bus.timing_e0[j] = W'($urandom_range(0, 40));
            bus.timing_e1[j] = W'($urandom_range(0, 40));
        end
    endtask

    task automatic set_axis(input int a, input int t0, input int t1, input int t2, input int t3);
        cur_t[a][0] = W'(t0); cur_t[a][1] = W'(t1); cur_t[a][2] = W'(t2); cur_t[a][3] = W'(t3);
    endtask

    task automatic clear_tables();
        for (int a = 0; a < 5; a++) set_axis(a, 0, 0, 0, 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".elapsed"}, bus.elapsed, 0);
        chk({tag, ".active"}, bus.axis_active, 0);
        chk({tag, ".seg"}, obs_segs(), 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".finish"}, bus.finish, 0);
        chk({tag, ".error"}, bus.error, 0);
    endtask

    task automatic check_run(input int e);
        chk("run.elapsed", bus.elapsed, W'(e));
        chk("run.busy", bus.busy, 1);
        chk("run.finish", bus.finish, 0);
        chk("run.active", bus.axis_active, ref_active(e));
        chk("run.seg", obs_segs(), ref_segs(e));
    endtask

    // One complete move from cur_t. hold_e/hold_len: hold asserted for hold_len cycles
    // while elapsed == hold_e. abort_e: start dropped while elapsed == abort_e (-1 = never).
    task automatic run_move(input int hold_e, input int hold_len, input int abort_e);
        int k, e, held, guard, t_max, exp_holds;
        t_max     = ref_max_t3();
        exp_holds = (hold_e >= 0 && hold_e < t_max) ? hold_len : 0;
        drive_tables();
        bus.start = 1'b1;
        bus.timings_valid = 1'b1;
        bus.hold = 1'b0;
        step();
        k = cyc;                          // cyc after the edge that sampled start&valid
        chk("check.busy", bus.busy, 1);
        chk("check.active", bus.axis_active, 0);
        chk("check.elapsed", bus.elapsed, 0);
        bus.timings_valid = 1'b0;
        scramble_tables();                // must not affect the latched move

        if (!ref_mono()) begin
            step();
            chk("err.error", bus.error, 1);
            chk("err.busy", bus.busy, 0);
            chk("err.finish", bus.finish, 0);
            chk("err.active", bus.axis_active, 0);
            step();
            chk("err.stay", bus.error, 1);
            bus.start = 1'b0;
            step();
            check_quiet("err_clear");
            return;
        end

        step();                           // first RUN cycle
        e = 0; held = 0; guard = 0;
        forever begin
            check_run(e);
            if (e == abort_e) begin
                bus.start = 1'b0;
                bus.hold  = 1'b0;
                step();
                check_quiet("abort");
                step();
                chk("abort.finish_later", bus.finish, 0);
                return;
            end
            if (ref_active(e) == 5'd0) break;
            bus.hold = (e == hold_e && held < hold_len);
            step();
            if (bus.hold) held++;
            else e++;
            guard++;
            if (guard > 500) begin
                n_total++;
                $error("FAIL %s.timeout observed=no_completion expected=done_within_500", tname);
                bus.start = 1'b0;
                bus.hold  = 1'b0;
                step();
                return;
            end
        end
        bus.hold = 1'b0;
        step();
        chk("done.finish", bus.finish, 1);
        chk("done.busy", bus.busy, 0);
        chk("done.error", bus.error, 0);
        chk("done.elapsed", bus.elapsed, W'(t_max));
        chk("done.active", bus.axis_active, 0);
        chk("done.seg", obs_segs(), 0);
        // finish first visible (k + 2 + T + holds) edges after start was sampled at edge k
        chk("done.latency", W'(cyc - k), W'(2 + t_max + exp_holds));
        step();
        chk("done.hold_finish", bus.finish, 1);
        chk("done.hold_elapsed", bus.elapsed, W'(t_max));
        bus.start = 1'b0;
        step();
        check_quiet("done_clear");
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.timings_valid = 1'b0;
        bus.hold = 1'b0;
        clear_tables();
        drive_tables();
        step();
        step();
        tname = "reset";
        check_quiet("reset");
        reset = 1'b0;
        step();
        check_quiet("idle");

        tname = "single_x";
        clear_tables();
        set_axis(0, 2, 5, 7, 10);
        run_move(-1, 0, -1);

        tname = "five_axes";
        clear_tables();
        set_axis(0, 1, 2, 3, 4);
        set_axis(1, 2, 3, 5, 6);
        set_axis(2, 0, 4, 4, 8);
        set_axis(3, 3, 6, 9, 10);
        set_axis(4, 4, 8, 10, 12);
        run_move(-1, 0, -1);

        tname = "hold";
        clear_tables();
        set_axis(0, 2, 5, 7, 10);
        run_move(3, 3, -1);

        tname = "bad_y";
        clear_tables();
        set_axis(0, 2, 5, 7, 10);
        set_axis(1, 5, 3, 7, 9);
        run_move(-1, 0, -1);

        tname = "rearm";
        clear_tables();
        set_axis(0, 2, 5, 7, 10);
        run_move(-1, 0, -1);

        tname = "abort";
        run_move(-1, 0, 6);

        tname = "all_zero";
        clear_tables();
        run_move(-1, 0, -1);

        tname = "reset_mid_run";
        clear_tables();
        set_axis(0, 2, 5, 7, 10);
        drive_tables();
        bus.start = 1'b1;
        bus.timings_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("pre.busy", bus.busy, 1);
        reset = 1'b1;
        step();
        check_quiet("post");
        reset = 1'b0;
        bus.start = 1'b0;
        bus.timings_valid = 1'b0;
        step();
        check_quiet("released");

        tname = "random";
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < 5; a++) begin
                int v0, v1, v2, v3;
                v0 = $urandom_range(0, 5);
                v1 = v0 + $urandom_range(0, 5);
                v2 = v1 + $urandom_range(0, 5);
                v3 = v2 + $urandom_range(0, 5);
                if ($urandom_range(0, 9) == 0) set_axis(a, 0, 0, 0, 0);
                else set_axis(a, v0, v1, v2, v3);
            end
            if ($urandom_range(0, 7) == 0) begin
                int a;
                a = $urandom_range(0, 4);
                cur_t[a][1] = cur_t[a][2] + 1;
            end
            run_move($urandom_range(0, 1) ? int'($urandom_range(0, 15)) : -1,
                     $urandom_range(1, 4),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/motion_phase_tracker.md
# motion_phase_tracker

Consumer side of the per-axis timing calculation. Latches the five 4-entry timing tables (X, Y, Z, E0, E1) once the calculator reports them complete, runs a single shared elapsed-cycle counter, and reports each axis's current motion segment to the step generators. Sits between the timing calculator and the per-axis step/velocity units in the speed-jerk-acc path.

## Interface
Parameters:
- CNT_W, 64, width of timing entries and elapsed counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  level; held high for the whole move, low returns the block to idle (abort)
- timings_valid  in  1  level; calculator finish, timing tables stable while high
- hold  in  1  freezes elapsed counter while in RUN
- timing_x, timing_y, timing_z, timing_e0, timing_e1  in  CNT_W each, [0:3]  cumulative segment boundaries t0..t3 in clk cycles
- elapsed  out  CNT_W  cycles since RUN entry
- axis_active  out  5  bit i = axis i still moving (order X,Y,Z,E0,E1 = bits 0..4)
- axis_seg  out  2 each, [0:4]  current segment per axis
- busy  out  1  CHECK or RUN
- finish  out  1  move complete, held in DONE
- error  out  1  non-monotonic timing table, held in ERR

## Operation
- States: IDLE, CHECK, RUN, DONE, ERR.
- IDLE: on cycle with start=1 and timings_valid=1, latch all 20 timing words; next state CHECK. Otherwise stay; elapsed=0.
- CHECK: for every axis verify t0<=t1<=t2<=t3 on latched copies. Any violation -> ERR; else RUN with elapsed=0.
- RUN: per axis, active = elapsed < t3. seg = 0 if elapsed<t0, 1 if elapsed<t1, 2 if elapsed<t2, else 3. Inactive axis: seg=0, active=0. Axis with t3=0 is never active.
- RUN: if no axis active at current elapsed -> DONE, counter stops. Else if hold=0 elapsed increments; hold=1 keeps elapsed (segments unchanged).
- Elapsed saturates at all-ones; no wrap.
- DONE: finish=1, elapsed frozen at final value, axis_active=0, axis_seg=0. Stays until start=0.
- ERR: error=1, busy=0, finish=0, axis outputs 0. Stays until start=0.
- start=0 in any state -> IDLE at next edge; elapsed cleared, finish/error cleared. Abort mid-RUN drops axis_active to 0 the cycle after.
- timings_valid only sampled in IDLE; changes on timing inputs after latch are ignored.
- Re-arm requires start low for at least one cycle after DONE/ERR.
- axis_active, axis_seg are combinational from latched timings, registered elapsed and registered state; all else registered.

## Timing
- Reset values: state IDLE, elapsed 0, axis_active 0, axis_seg all 0, busy 0, finish 0, error 0; latched timings 0.
- start&timings_valid sampled at edge k -> CHECK during cycle k+1 (busy=1) -> RUN first cycle k+2 with elapsed=0.
- Max t3 = T, no hold: RUN lasts T+1 cycles (elapsed 0..T); finish=1 from cycle k+3+T.
- Each hold cycle in RUN delays finish by one cycle.
- All t3=0: one RUN cycle, finish at k+3.
- Abort at edge m: busy/finish/error low in cycle m+1.
- reset overrides everything in the same edge, including mid-RUN.

## Test plan
- Single axis X t=(2,5,7,10), others zero; start+valid -> seg sequence 0,0,1,1,1,2,2,3,3,3 at elapsed 0..9, active low at elapsed 10, finish at k+13, elapsed holds 10.
- All five axes different lengths (X t3=4, E1 t3=12) -> axis_active bits drop individually at elapsed 4 and 12; finish only after 12; busy low with finish high.
- hold=1 for 3 cycles at elapsed 3 of X t=(2,5,7,10) -> elapsed stays 3, seg stays 1, finish delayed exactly 3 cycles.
- Y table t=(5,3,7,9) -> ERR after CHECK, error=1, busy=0, finish=0; drop start -> error=0 next cycle; re-arm with valid tables runs normally.
- start dropped at elapsed 6 -> next cycle IDLE, elapsed=0, axis_active=0, finish never asserted; changing timing inputs during RUN has no effect on segments.
- All t3=0 -> one RUN cycle, finish at k+3, elapsed=0; reset asserted mid-RUN -> all outputs reset values next cycle.
